// File: rtl/lcd_bus_responder_if.sv
// CPU load/store bus as seen by a memory-mapped peripheral.
interface lcd_bus_responder_if;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output we, re, addr, wdata, input rdata, hit);
    modport slave  (input we, re, addr, wdata, output rdata, hit);
endinterface

// File: rtl/lcd_bus_responder.sv
// Bus responder that queues LCD bytes in a 4-entry FIFO and plays them out
// as HD44780 write cycles (setup, enable pulse, hold, execution wait).
module lcd_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_4000,
    parameter int          T_AS        = 3,
    parameter int          T_PW        = 25,
    parameter int          T_HOLD      = 3,
    parameter int          T_EXEC      = 2000,
    parameter int          T_EXEC_LONG = 82000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    lcd_bus_responder_if.slave   bus,
    output logic                 o_busy,
    output logic [31:0]          o_io_lcd
);
    localparam int CW = $clog2(T_AS + T_PW + T_HOLD + T_EXEC + T_EXEC_LONG + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

    logic [8:0]    fifo_mem [4];
    logic [1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [2:0]    count_reg;
    logic          overflow_reg, on_reg, en_reg, rs_reg;
    logic [7:0]    data_reg;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;

    logic       hit_data, hit_ctrl, ctrl_wr, fifo_empty, fifo_full;
    logic       pop, push, drop, long_cmd;
    logic [8:0] head;
    logic       unused_wdata;

    assign hit_data   = (bus.addr == BASE_ADDR);
    assign hit_ctrl   = (bus.addr == BASE_ADDR + 32'd4);
    assign bus.hit    = hit_data | hit_ctrl;
    assign ctrl_wr    = bus.we & hit_ctrl;
    assign fifo_empty = (count_reg == 3'd0);
    assign fifo_full  = (count_reg == 3'd4);
    assign pop        = (state_reg == IDLE) & ~fifo_empty;
    // A full FIFO still accepts a write when the sequencer frees a slot on the same edge.
    assign push       = bus.we & hit_data & (~fifo_full | pop);
    assign drop       = bus.we & hit_data & fifo_full & ~pop;
    assign head       = fifo_mem[rd_ptr_reg];
    assign long_cmd   = ~rs_reg & (data_reg != 8'h00) & (data_reg < 8'h04);
    assign unused_wdata = ^bus.wdata[31:9];

    assign o_busy   = ~fifo_empty | (state_reg != IDLE);
    assign o_io_lcd = {on_reg, 20'b0, en_reg, rs_reg, 1'b0, data_reg};

    always_comb begin
        bus.rdata = 32'b0;
        if (bus.re && hit_data)
            bus.rdata = {25'b0, count_reg, overflow_reg, fifo_empty, fifo_full, o_busy};
        else if (bus.re && hit_ctrl)
            bus.rdata = {31'b0, on_reg};
    end

    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= bus.wdata[8:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            count_reg    <= 3'd0;
            overflow_reg <= 1'b0;
            on_reg       <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
            if (ctrl_wr && bus.wdata[1])
                overflow_reg <= 1'b0;
            else if (drop)
                overflow_reg <= 1'b1;
            if (ctrl_wr)
                on_reg <= bus.wdata[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            en_reg    <= 1'b0;
            rs_reg    <= 1'b0;
            data_reg  <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        rs_reg    <= head[8];
                        data_reg  <= head[7:0];
                        cnt_reg   <= CW'(T_AS - 1);
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        en_reg    <= 1'b1;
                        cnt_reg   <= CW'(T_PW - 1);
                        state_reg <= PULSE;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt_reg == '0) begin
                        en_reg    <= 1'b0;
                        cnt_reg   <= CW'(T_HOLD - 1);
                        state_reg <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        cnt_reg   <= long_cmd ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
                        state_reg <= EXEC;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                EXEC: begin
                    if (cnt_reg == '0)
                        state_reg <= IDLE;
                    else
                        cnt_reg <= cnt_reg - CW'(1);
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench: stimulus queues expected LCD words, a monitor checks each EN pulse.
module tb_lcd_bus_responder;
    localparam logic [31:0] BASE = 32'h1000_4000;
    localparam int T_PW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] io_lcd;

    lcd_bus_responder_if bif();

    lcd_bus_responder #(
        .BASE_ADDR(BASE), .T_AS(1), .T_PW(T_PW), .T_HOLD(1), .T_EXEC(4), .T_EXEC_LONG(10)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bif.slave), .o_busy(busy), .o_io_lcd(io_lcd)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses_seen = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every EN rising edge must carry the next queued word; every pulse lasts T_PW cycles.
    logic en_prev = 1'b0;
    int   width = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 1'b0;
            width   = 0;
        end else begin
            if (io_lcd[10] && !en_prev) begin
                pulses_seen++;
                width = 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lcd_word: unexpected EN pulse carrying 0x%03h", io_lcd[9:0]);
                end else begin
                    check("lcd_word", {22'b0, io_lcd[9:0]}, {22'b0, exp_q.pop_front()});
                end
            end else if (io_lcd[10]) begin
                width++;
            end else if (en_prev) begin
                check("en_width", width, T_PW);
            end
            en_prev = io_lcd[10];
        end
    end

    task automatic bus_idle();
        bif.we = 1'b0; bif.re = 1'b0; bif.addr = 32'h0; bif.wdata = 32'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bif.we = 1'b1; bif.addr = addr; bif.wdata = data;
        @(negedge clk);
        bif.we = 1'b0;
    endtask

    task automatic push_data(input logic [8:0] w);
        exp_q.push_back({w[8], 1'b0, w[7:0]});
        wr(BASE, {23'b0, w});
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bif.re = 1'b1; bif.addr = addr;
        #1;
        check(name, bif.rdata, exp);
        bif.re = 1'b0; bif.addr = 32'h0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    // Called right after the write edge E; walks edges E+1 .. E+5+exec.
    task automatic run_timing(input string name, input logic [9:0] word, input int exec);
        for (int k = 1; k <= 5 + exec; k++) begin
            @(negedge clk);
            if (k == 1)
                check({name, "_popword"}, {22'b0, io_lcd[9:0]}, {22'b0, word});
            check($sformatf("%s_en_busy_e%0d", name, k), {30'b0, io_lcd[10], busy},
                  {30'b0, (k == 2 || k == 3), (k < 5 + exec)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus_idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_io_lcd", io_lcd, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rd_check("rst_status", BASE, 32'h04);
        rd_check("rst_ctrl", BASE + 32'd4, 32'h0);

        // Scenario 1: single data write
        push_data(9'h141);
        run_timing("s1", 10'h241, 4);

        // Scenario 2: clear command uses the long wait, others the short one
        push_data(9'h001);
        run_timing("s2clr", 10'h001, 10);
        push_data(9'h004);
        run_timing("s2norm", 10'h004, 4);

        // Scenario 3: six back-to-back writes, the sixth overflows
        p0 = pulses_seen;
        bif.we = 1'b1; bif.addr = BASE;
        for (int i = 0; i < 6; i++) begin
            bif.wdata = 32'h150 + i;
            if (i < 5) exp_q.push_back({1'b1, 1'b0, 8'h50 + 8'(i)});
            @(negedge clk);
        end
        bif.we = 1'b0;
        rd_check("s3_status_busy", BASE, 32'h4B);
        wait_idle(100);
        check("s3_pulses", pulses_seen - p0, 5);
        rd_check("s3_status_idle", BASE, 32'h0C);
        wr(BASE + 32'd4, 32'h2);
        rd_check("s3_ovf_cleared", BASE, 32'h04);

        // Scenario 4: write lands on the pop edge of a full FIFO
        bif.we = 1'b1; bif.addr = BASE;
        for (int i = 0; i < 5; i++) begin
            bif.wdata = 32'h160 + i;
            exp_q.push_back({1'b1, 1'b0, 8'h60 + 8'(i)});
            @(negedge clk);
        end
        bif.we = 1'b0;
        rd_check("s4_full", BASE, 32'h43);
        repeat (5) @(negedge clk);
        rd_check("s4_full_idle", BASE, 32'h43);
        push_data(9'h165);
        check("s4_popword", {22'b0, io_lcd[9:0]}, 32'h261);
        rd_check("s4_count_kept", BASE, 32'h43);
        wait_idle(200);
        rd_check("s4_no_ovf", BASE, 32'h04);

        // Scenario 5: asynchronous reset during the enable pulse
        push_data(9'h141);
        begin
            int k = 0;
            while (!io_lcd[10] && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("s5_en_seen", {31'b0, io_lcd[10]}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("s5_rst_io_lcd", io_lcd, 32'h0);
        check("s5_rst_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        rd_check("s5_status", BASE, 32'h04);
        push_data(9'h141);
        run_timing("s5", 10'h241, 4);

        // Scenario 6: ON register, decode misses
        wr(BASE + 32'd4, 32'h1);
        rd_check("s6_ctrl", BASE + 32'd4, 32'h1);
        check("s6_on_pin", {31'b0, io_lcd[31]}, 32'h1);
        bif.re = 1'b1; bif.addr = BASE + 32'd8;
        #1;
        check("s6_miss_rdata", bif.rdata, 32'h0);
        check("s6_miss_hit", {31'b0, bif.hit}, 32'h0);
        bif.addr = BASE + 32'd4;
        #1;
        check("s6_ctrl_hit", {31'b0, bif.hit}, 32'h1);
        bif.re = 1'b0;
        wr(BASE + 32'd8, 32'h141);
        @(negedge clk);
        check("s6_miss_busy", {31'b0, busy}, 32'h0);
        rd_check("s6_miss_status", BASE, 32'h04);
        rd_check("s6_miss_ctrl", BASE + 32'd4, 32'h1);
        push_data(9'h155);
        run_timing("s6", 10'h255, 4);
        check("s6_on_kept", {31'b0, io_lcd[31]}, 32'h1);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
